hazard_pipe_ctrl: RTL and testbench

- Producer side of the operand-forwarding path in the 5-stage pipelined CPU.
- Carries each instruction's destination register and write/read flags down the ID/EX -> EX/MEM -> MEM/WB chain. Drives IDEXRs, IDEXRt, EXMEMRd, MEMWBRd, EXMEMRegWrite and MEMWBRegWrite to the forwarding logic.
- Detects hazards that forwarding cannot cover and generates PC/IF-ID stall, bubble insertion and branch flush.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_pipe_ctrl_if.sv | 40 ++++
 rtl/hazard_pipe_ctrl.sv | 92 +++++++++
 tb/tb_hazard_pipe_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_pipe_ctrl_if.sv
// Bundle between ID-stage decode and hazard/forwarding control: ID fields in, stage registers and stall/flush controls out.
// Latency and backpressure are set by the attached controller; the bundle itself is wiring only.
interface hazard_pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IFIDRs;
  logic [4:0]       IFIDRt;
  logic             IDUsesRt;
  logic [4:0]       IDRd;
  logic             IDRegWrite;
  logic             IDMemRead;
  logic             EXBranchTaken;

  logic [4:0]       IDEXRs;
  logic [4:0]       IDEXRt;
  logic [4:0]       IDEXRd;
  logic             IDEXRegWrite;
  logic             IDEXMemRead;
  logic [4:0]       EXMEMRd;
  logic             EXMEMRegWrite;
  logic [4:0]       MEMWBRd;
  logic             MEMWBRegWrite;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             Stall;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output IFIDRs, IFIDRt, IDUsesRt, IDRd, IDRegWrite, IDMemRead, EXBranchTaken,
    input  IDEXRs, IDEXRt, IDEXRd, IDEXRegWrite, IDEXMemRead, EXMEMRd, EXMEMRegWrite,
           MEMWBRd, MEMWBRegWrite, PCWrite, IFIDWrite, IFIDFlush, Stall, StallCount
  );

  modport slave (
    input  IFIDRs, IFIDRt, IDUsesRt, IDRd, IDRegWrite, IDMemRead, EXBranchTaken,
    output IDEXRs, IDEXRt, IDEXRd, IDEXRegWrite, IDEXMemRead, EXMEMRd, EXMEMRegWrite,
           MEMWBRd, MEMWBRegWrite, PCWrite, IFIDWrite, IFIDFlush, Stall, StallCount
  );
endinterface

// File: rtl/hazard_pipe_ctrl.sv
// Hazard control: carries dest/flags down ID/EX->EX/MEM->MEM/WB; stall, bubble, flush; saturating stall counter.
// Latency: one cycle per stage, controls combinational; chain never freezes, only PC and IF/ID hold on stall.
module hazard_pipe_ctrl #(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_pipe_ctrl_if.slave  bus
);

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } idex_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
  } dst_t;

  idex_t            idex_q;
  idex_t            idex_d;
  dst_t             exmem_q;
  dst_t             memwb_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic hit_ex;
  logic hit_mem;
  logic hz;
  logic stall;
  logic bubble;

  // $zero is hardwired, so it can never be a true dependency.
  assign hit_ex  = (idex_q.rd != 5'd0) &&
                   ((idex_q.rd == bus.IFIDRs) || (bus.IDUsesRt && (idex_q.rd == bus.IFIDRt)));
  assign hit_mem = (exmem_q.rd != 5'd0) &&
                   ((exmem_q.rd == bus.IFIDRs) || (bus.IDUsesRt && (exmem_q.rd == bus.IFIDRt)));

  // MEM/WB is excluded: the register file writes before it reads within a cycle.
  assign hz = FWD_EN ? (idex_q.mem_read && hit_ex)
                     : ((idex_q.reg_write && hit_ex) || (exmem_q.reg_write && hit_mem));

  assign stall  = hz && !bus.EXBranchTaken;
  assign bubble = stall || bus.EXBranchTaken;

  always_comb begin
    idex_d = '0;
    if (!bubble) begin
      idex_d.rs        = bus.IFIDRs;
      idex_d.rt        = bus.IFIDRt;
      idex_d.rd        = bus.IDRd;
      idex_d.reg_write = bus.IDRegWrite;
      idex_d.mem_read  = bus.IDMemRead;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q      <= '0;
      exmem_q     <= '0;
      memwb_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      idex_q            <= idex_d;
      exmem_q.rd        <= idex_q.rd;
      exmem_q.reg_write <= idex_q.reg_write;
      memwb_q           <= exmem_q;
      if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.IDEXRs        = idex_q.rs;
  assign bus.IDEXRt        = idex_q.rt;
  assign bus.IDEXRd        = idex_q.rd;
  assign bus.IDEXRegWrite  = idex_q.reg_write;
  assign bus.IDEXMemRead   = idex_q.mem_read;
  assign bus.EXMEMRd       = exmem_q.rd;
  assign bus.EXMEMRegWrite = exmem_q.reg_write;
  assign bus.MEMWBRd       = memwb_q.rd;
  assign bus.MEMWBRegWrite = memwb_q.reg_write;
  assign bus.PCWrite       = !stall;
  assign bus.IFIDWrite     = !stall;
  assign bus.IFIDFlush     = bus.EXBranchTaken;
  assign bus.Stall         = stall;
  assign bus.StallCount    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl: unit a (forwarding, 4-bit counter) and unit b (no forwarding, 16-bit counter) share ID stimulus.
// Directed scenarios plus random traffic, compared every cycle against an instruction-level pipeline model.
module tb_hazard_pipe_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } inst_t;

  localparam int FWD [2] = '{1, 0};
  localparam int CW  [2] = '{4, 16};

  logic clk;
  logic rst_n;

  logic [4:0] in_rs, in_rt, in_rd;
  logic       in_ut, in_rw, in_mr, in_br;

  hazard_pipe_ctrl_if #(.CNT_W(4))  ifa ();
  hazard_pipe_ctrl_if #(.CNT_W(16)) ifb ();

  hazard_pipe_ctrl #(.FWD_EN(1'b1), .CNT_W(4))  dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  hazard_pipe_ctrl #(.FWD_EN(1'b0), .CNT_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  assign ifa.IFIDRs = in_rs;  assign ifb.IFIDRs = in_rs;
  assign ifa.IFIDRt = in_rt;  assign ifb.IFIDRt = in_rt;
  assign ifa.IDUsesRt = in_ut;  assign ifb.IDUsesRt = in_ut;
  assign ifa.IDRd = in_rd;  assign ifb.IDRd = in_rd;
  assign ifa.IDRegWrite = in_rw;  assign ifb.IDRegWrite = in_rw;
  assign ifa.IDMemRead = in_mr;  assign ifb.IDMemRead = in_mr;
  assign ifa.EXBranchTaken = in_br;  assign ifb.EXBranchTaken = in_br;

  logic [32:0] obs_a, obs_b;
  assign obs_a = {ifa.IDEXRs, ifa.IDEXRt, ifa.IDEXRd, ifa.IDEXRegWrite, ifa.IDEXMemRead,
                  ifa.EXMEMRd, ifa.EXMEMRegWrite, ifa.MEMWBRd, ifa.MEMWBRegWrite,
                  ifa.PCWrite, ifa.IFIDWrite, ifa.IFIDFlush, ifa.Stall};
  assign obs_b = {ifb.IDEXRs, ifb.IDEXRt, ifb.IDEXRd, ifb.IDEXRegWrite, ifb.IDEXMemRead,
                  ifb.EXMEMRd, ifb.EXMEMRegWrite, ifb.MEMWBRd, ifb.MEMWBRegWrite,
                  ifb.PCWrite, ifb.IFIDWrite, ifb.IFIDFlush, ifb.Stall};

  int n_chk = 0;
  int n_err = 0;

  // Reference pipeline: one instruction record per stage, per unit.
  inst_t       m_ex  [2];
  inst_t       m_mem [2];
  inst_t       m_wb  [2];
  int unsigned m_cnt [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit reads(input logic [4:0] r);
    return (r != 5'd0) && ((r == in_rs) || (in_ut && (r == in_rt)));
  endfunction

  function automatic bit m_stall(input int k);
    bit hz;
    if (FWD[k] != 0) hz = m_ex[k].mr && reads(m_ex[k].rd);
    else             hz = (m_ex[k].rw && reads(m_ex[k].rd)) || (m_mem[k].rw && reads(m_mem[k].rd));
    return hz && !in_br;
  endfunction

  function automatic logic [32:0] m_obs(input int k);
    bit s;
    s = m_stall(k);
    return {m_ex[k].rs, m_ex[k].rt, m_ex[k].rd, m_ex[k].rw, m_ex[k].mr,
            m_mem[k].rd, m_mem[k].rw, m_wb[k].rd, m_wb[k].rw,
            !s, !s, in_br, s};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_advance();
    bit s;
    for (int k = 0; k < 2; k++) begin
      s = m_stall(k);
      m_wb[k]  = m_mem[k];
      m_mem[k] = m_ex[k];
      m_ex[k]  = (s || in_br) ? inst_t'(0) : inst_t'({in_rs, in_rt, in_rd, in_rw, in_mr});
      if (s && (m_cnt[k] < (32'd1 << CW[k]) - 1)) m_cnt[k]++;
    end
  endtask

  task automatic check_model();
    chk("a_obs", 64'(obs_a), 64'(m_obs(0)));
    chk("a_cnt", 64'(ifa.StallCount), 64'(m_cnt[0]));
    chk("b_obs", 64'(obs_b), 64'(m_obs(1)));
    chk("b_cnt", 64'(ifb.StallCount), 64'(m_cnt[1]));
  endtask

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                     input logic [4:0] rd, input logic rw, input logic mr, input logic br);
    @(negedge clk);
    in_rs = rs; in_rt = rt; in_ut = ut; in_rd = rd; in_rw = rw; in_mr = mr; in_br = br;
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      drv(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned saved;
    rst_n = 1'b0;
    in_rs = '0; in_rt = '0; in_rd = '0; in_ut = 1'b0; in_rw = 1'b0; in_mr = 1'b0; in_br = 1'b0;
    model_reset();
    #2;
    chk("rst_a_obs", 64'(obs_a), 64'h0000_000C);
    chk("rst_b_obs", 64'(obs_b), 64'h0000_000C);
    chk("rst_a_cnt", 64'(ifa.StallCount), 64'd0);
    #1 rst_n = 1'b1;

    // Load-use: lw $8 then add reading $8.
    drv(5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drv(5'd8, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    chk("lu_stall", 64'(ifa.Stall), 64'd1);
    chk("lu_pcwrite", 64'(ifa.PCWrite), 64'd0);
    chk("lu_ifidwrite", 64'(ifa.IFIDWrite), 64'd0);
    tick();
    chk("lu_bubble_rd", 64'(ifa.IDEXRd), 64'd0);
    chk("lu_bubble_mr", 64'(ifa.IDEXMemRead), 64'd0);
    chk("lu_cnt", 64'(ifa.StallCount), 64'd1);
    drv(5'd8, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    chk("lu_release", 64'(ifa.Stall), 64'd0);
    tick();

    // ALU RAW with forwarding: no stall, destination walks down the chain.
    drv(5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    chk("alu_idexrd", 64'(ifa.IDEXRd), 64'd5);
    drv(5'd5, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("alu_nostall", 64'(ifa.Stall), 64'd0);
    tick();
    chk("alu_exmemrd", 64'(ifa.EXMEMRd), 64'd5);
    chk("alu_exmemrw", 64'(ifa.EXMEMRegWrite), 64'd1);
    drv(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("alu_memwbrd", 64'(ifa.MEMWBRd), 64'd5);

    // No forwarding: consumer of rt=$5 stalls two cycles.
    nops(3);
    saved = m_cnt[1];
    drv(5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drv(5'd1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("nf_stall1", 64'(ifb.Stall), 64'd1);
    tick();
    drv(5'd1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("nf_stall2", 64'(ifb.Stall), 64'd1);
    tick();
    drv(5'd1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("nf_release", 64'(ifb.Stall), 64'd0);
    chk("nf_cnt", 64'(ifb.StallCount), 64'(saved + 2));
    tick();

    // Branch flush wins over a simultaneous load-use hazard.
    nops(3);
    drv(5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    saved = m_cnt[0];
    drv(5'd8, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    chk("fl_flush", 64'(ifa.IFIDFlush), 64'd1);
    chk("fl_pcwrite", 64'(ifa.PCWrite), 64'd1);
    chk("fl_stall", 64'(ifa.Stall), 64'd0);
    tick();
    chk("fl_bubble", 64'({ifa.IDEXRd, ifa.IDEXRegWrite, ifa.IDEXMemRead}), 64'd0);
    chk("fl_cnt", 64'(ifa.StallCount), 64'(saved));

    // $zero destination and rt-not-read masking.
    drv(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drv(5'd0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("zero_nostall", 64'(ifa.Stall), 64'd0);
    tick();
    drv(5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    drv(5'd1, 5'd9, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("usesrt_nostall", 64'(ifa.Stall), 64'd0);
    tick();

    // Random traffic over a small register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      drv(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
      tick();
    end

    // Saturate the 4-bit counter with 20 load-use stalls.
    for (int i = 0; i < 20; i++) begin
      drv(5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
      tick();
      drv(5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("sat_cnt", 64'(ifa.StallCount), 64'd15);

    // Reset asserted in the middle of a stall, checked before any clock edge.
    drv(5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drv(5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("mid_stall", 64'(ifa.Stall), 64'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_obs", 64'(obs_a), 64'h0000_000C);
    chk("arst_cnt", 64'(ifa.StallCount), 64'd0);
    chk("arst_pcwrite", 64'(ifa.PCWrite), 64'd1);
    check_model();
    #1 rst_n = 1'b1;
    tick();
    nops(3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
